// File: rtl/tcb_lite_gpio_irq.sv
// TCB-lite GPIO with synchronized inputs, sticky rise/fall capture and a masked level irq.
// Read data and error are registered one cycle after the transfer; tcb_rdy is always 1.
module tcb_lite_gpio_irq #(
   parameter int unsigned GPIO_DAT = 32,
   parameter int unsigned CDC_LEN  = 2
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                tcb_vld,
   output logic                tcb_rdy,
   input  logic                tcb_wen,
   input  logic [4:0]          tcb_adr,
   input  logic [3:0]          tcb_ben,
   input  logic [31:0]         tcb_wdt,
   output logic [31:0]         tcb_rdt,
   output logic                tcb_err,
   output logic [GPIO_DAT-1:0] gpio_o,
   output logic [GPIO_DAT-1:0] gpio_e,
   input  logic [GPIO_DAT-1:0] gpio_i,
   output logic                irq
);

   localparam int unsigned ARM_CNT = CDC_LEN + 1;
   localparam int unsigned ARM_W   = $clog2(ARM_CNT + 1);

   typedef enum logic [2:0] {
      ADR_OUT  = 3'd0,
      ADR_ENA  = 3'd1,
      ADR_IN   = 3'd2,
      ADR_RISE = 3'd3,
      ADR_FALL = 3'd4,
      ADR_MSKR = 3'd5,
      ADR_MSKF = 3'd6,
      ADR_NONE = 3'd7
   } adr_e;

   logic                trn;
   logic                wr;
   logic                rd;
   adr_e                adr;
   logic [31:0]         lane32;
   logic [GPIO_DAT-1:0] lane;
   logic [GPIO_DAT-1:0] wdt;
   logic [31:0]         rdata;

   logic [GPIO_DAT-1:0] out_q;
   logic [GPIO_DAT-1:0] ena_q;
   logic [GPIO_DAT-1:0] rise_q;
   logic [GPIO_DAT-1:0] fall_q;
   logic [GPIO_DAT-1:0] mskr_q;
   logic [GPIO_DAT-1:0] mskf_q;

   logic [GPIO_DAT-1:0] sync_q [CDC_LEN];
   logic [GPIO_DAT-1:0] sync;
   logic [GPIO_DAT-1:0] prev_q;
   logic [ARM_W-1:0]    arm_cnt;
   logic                armed;
   logic [GPIO_DAT-1:0] rise_ev;
   logic [GPIO_DAT-1:0] fall_ev;
   logic [GPIO_DAT-1:0] rise_clr;
   logic [GPIO_DAT-1:0] fall_clr;

   logic unused_ok;

   assign tcb_rdy = 1'b1;
   assign trn     = tcb_vld & tcb_rdy;
   assign wr      = trn &  tcb_wen;
   assign rd      = trn & ~tcb_wen;
   assign adr     = adr_e'(tcb_adr[4:2]);
   assign lane32  = {{8{tcb_ben[3]}}, {8{tcb_ben[2]}}, {8{tcb_ben[1]}}, {8{tcb_ben[0]}}};
   assign lane    = lane32[GPIO_DAT-1:0];
   assign wdt     = tcb_wdt[GPIO_DAT-1:0];

   assign unused_ok = ^{tcb_adr[1:0], tcb_wdt, lane32};

   assign gpio_o = out_q;
   assign gpio_e = ena_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(CDC_LEN); i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int i = 1; i < int'(CDC_LEN); i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync;
      end
   end

   assign sync = sync_q[CDC_LEN-1];

   // Edges stay masked until both sync and prev hold real pad samples,
   // otherwise a pin high at reset release looks like a rising edge.
   always_ff @(posedge clk) begin
      if (rst)         arm_cnt <= '0;
      else if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
   end

   assign armed   = (arm_cnt == ARM_W'(ARM_CNT));
   assign rise_ev = armed ? ( sync & ~prev_q) : '0;
   assign fall_ev = armed ? (~sync &  prev_q) : '0;

   assign rise_clr = (wr && adr == ADR_RISE) ? (wdt & lane) : '0;
   assign fall_clr = (wr && adr == ADR_FALL) ? (wdt & lane) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         ena_q  <= '0;
         mskr_q <= '0;
         mskf_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         if (wr && adr == ADR_OUT)  out_q  <= (out_q  & ~lane) | (wdt & lane);
         if (wr && adr == ADR_ENA)  ena_q  <= (ena_q  & ~lane) | (wdt & lane);
         if (wr && adr == ADR_MSKR) mskr_q <= (mskr_q & ~lane) | (wdt & lane);
         if (wr && adr == ADR_MSKF) mskf_q <= (mskf_q & ~lane) | (wdt & lane);
         // Event OR-ed after the clear so a coinciding event survives.
         rise_q <= (rise_q & ~rise_clr) | rise_ev;
         fall_q <= (fall_q & ~fall_clr) | fall_ev;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= |((rise_q & mskr_q) | (fall_q & mskf_q));
   end

   always_comb begin
      rdata = '0;
      case (adr)
         ADR_OUT:  rdata = 32'(out_q);
         ADR_ENA:  rdata = 32'(ena_q);
         ADR_IN:   rdata = 32'(sync);
         ADR_RISE: rdata = 32'(rise_q);
         ADR_FALL: rdata = 32'(fall_q);
         ADR_MSKR: rdata = 32'(mskr_q);
         ADR_MSKF: rdata = 32'(mskf_q);
         default:  rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcb_rdt <= '0;
         tcb_err <= 1'b0;
      end else begin
         tcb_err <= trn && (adr == ADR_NONE);
         if (rd) tcb_rdt <= rdata;
      end
   end

endmodule

// File: tb/tb_tcb_lite_gpio_irq.sv
// Directed and randomized bench for tcb_lite_gpio_irq against a register-level reference model.
module tb_tcb_lite_gpio_irq;

   localparam int GPIO_DAT = 32;
   localparam int CDC_LEN  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tcb_vld = 1'b0;
   logic        tcb_rdy;
   logic        tcb_wen = 1'b0;
   logic [4:0]  tcb_adr = '0;
   logic [3:0]  tcb_ben = '0;
   logic [31:0] tcb_wdt = '0;
   logic [31:0] tcb_rdt;
   logic        tcb_err;
   logic [31:0] gpio_o;
   logic [31:0] gpio_e;
   logic [31:0] gpio_i;
   logic        irq;

   logic        loop_en = 1'b0;
   logic [31:0] pin_drv = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

   // Pull-up loopback: enabled pins follow gpio_o, the rest float high.
   assign gpio_i = loop_en ? ((gpio_o & gpio_e) | ~gpio_e) : pin_drv;

   tcb_lite_gpio_irq #(.GPIO_DAT(GPIO_DAT), .CDC_LEN(CDC_LEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .tcb_vld (tcb_vld),
      .tcb_rdy (tcb_rdy),
      .tcb_wen (tcb_wen),
      .tcb_adr (tcb_adr),
      .tcb_ben (tcb_ben),
      .tcb_wdt (tcb_wdt),
      .tcb_rdt (tcb_rdt),
      .tcb_err (tcb_err),
      .gpio_o  (gpio_o),
      .gpio_e  (gpio_e),
      .gpio_i  (gpio_i),
      .irq     (irq)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] m_out, m_ena, m_pad, m_rise, m_fall, m_mskr, m_mskf, m_rdt;
   logic [31:0] d;
   logic        e;

   function automatic logic [31:0] lanes(input logic [3:0] b);
      return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
   endfunction

   function automatic logic [31:0] m_read(input int a);
      case (a)
         0:       return m_out;
         1:       return m_ena;
         2:       return m_pad;
         3:       return m_rise;
         4:       return m_fall;
         5:       return m_mskr;
         6:       return m_mskf;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic m_irq();
      return |((m_rise & m_mskr) | (m_fall & m_mskf));
   endfunction

   task automatic m_write(input int a, input logic [31:0] wd, input logic [3:0] b);
      logic [31:0] mk;
      mk = lanes(b);
      case (a)
         0: m_out  = (m_out  & ~mk) | (wd & mk);
         1: m_ena  = (m_ena  & ~mk) | (wd & mk);
         3: m_rise = m_rise & ~(wd & mk);
         4: m_fall = m_fall & ~(wd & mk);
         5: m_mskr = (m_mskr & ~mk) | (wd & mk);
         6: m_mskf = (m_mskf & ~mk) | (wd & mk);
         default: ;
      endcase
   endtask

   task automatic m_reset();
      m_out = '0; m_ena = '0; m_rise = '0; m_fall = '0;
      m_mskr = '0; m_mskf = '0; m_rdt = '0;
   endtask

   // A stable pad change produces rise on 0->1 bits and fall on 1->0 bits.
   task automatic pad_model(input logic [31:0] nv);
      m_rise = m_rise | (nv & ~m_pad);
      m_fall = m_fall | (~nv & m_pad);
      m_pad  = nv;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic bus_rd(input int a, output logic [31:0] rd, output logic re);
      tcb_vld = 1'b1; tcb_wen = 1'b0; tcb_adr = 5'(a << 2); tcb_ben = 4'h0;
      @(posedge clk);
      @(negedge clk);
      tcb_vld = 1'b0;
      rd = tcb_rdt;
      re = tcb_err;
   endtask

   task automatic bus_wr(input int a, input logic [31:0] wd, input logic [3:0] b, output logic we);
      tcb_vld = 1'b1; tcb_wen = 1'b1; tcb_adr = 5'(a << 2); tcb_ben = b; tcb_wdt = wd;
      @(posedge clk);
      @(negedge clk);
      tcb_vld = 1'b0; tcb_wen = 1'b0;
      we = tcb_err;
   endtask

   task automatic rd_chk(input int a, input string tag);
      bus_rd(a, d, e);
      m_rdt = m_read(a);
      chk(tag, d, m_rdt);
      chk({tag, "_err"}, 32'(e), 32'(a == 7));
   endtask

   task automatic wr_chk(input int a, input logic [31:0] wd, input logic [3:0] b, input string tag);
      bus_wr(a, wd, b, e);
      m_write(a, wd, b);
      chk({tag, "_err"}, 32'(e), 32'(a == 7));
      chk({tag, "_rdt_hold"}, tcb_rdt, m_rdt);
   endtask

   task automatic set_pad(input logic [31:0] nv);
      pad_model(nv);
      pin_drv = nv;
      idle(CDC_LEN + 3);
   endtask

   initial begin
      m_reset();
      m_pad = 32'hFFFF_FFFF;
      @(negedge clk);
      idle(2);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_rdt", tcb_rdt, 0);
      chk("rst_err", 32'(tcb_err), 0);
      chk("rst_rdy", 32'(tcb_rdy), 1);
      rst = 1'b0;

      // IN becomes visible exactly CDC_LEN edges after reset release.
      for (int k = 1; k <= CDC_LEN + 1; k++) begin
         tcb_vld = (k >= CDC_LEN); tcb_wen = 1'b0; tcb_adr = 5'(2 << 2);
         @(posedge clk);
         @(negedge clk);
         if (k == CDC_LEN)     chk("in_early", tcb_rdt, 32'h0);
         if (k == CDC_LEN + 1) chk("in_sync", tcb_rdt, 32'hFFFF_FFFF);
      end
      tcb_vld = 1'b0;
      m_rdt = 32'hFFFF_FFFF;
      idle(2);
      for (int a = 0; a < 8; a++) rd_chk(a, $sformatf("map%0d", a));
      idle(1);
      chk("err_idle", 32'(tcb_err), 0);

      // Loopback: OUT set before ENA so pins only make the final transition.
      loop_en = 1'b1;
      wr_chk(0, 32'h0000_00A5, 4'hF, "lb_out");
      idle(CDC_LEN + 3);
      wr_chk(1, 32'h0000_00FF, 4'hF, "lb_ena");
      pad_model((m_out & m_ena) | ~m_ena);
      idle(CDC_LEN + 3);
      chk("lb_gpio_o", gpio_o, m_out);
      chk("lb_gpio_e", gpio_e, m_ena);
      rd_chk(2, "lb_in");
      rd_chk(3, "lb_rise");
      rd_chk(4, "lb_fall");
      pin_drv = m_pad;
      loop_en = 1'b0;

      wr_chk(0, 32'h1234_5678, 4'b0101, "ben_wr");
      chk("ben_gpio_o", gpio_o, m_out);
      rd_chk(0, "ben_out");

      // Edge irq timing on pin 0.
      wr_chk(3, 32'hFFFF_FFFF, 4'hF, "clr_rise");
      wr_chk(4, 32'hFFFF_FFFF, 4'hF, "clr_fall");
      set_pad(m_pad & ~32'h1);
      wr_chk(4, 32'hFFFF_FFFF, 4'hF, "clr_fall2");
      wr_chk(5, 32'h1, 4'hF, "mskr");
      idle(1);
      chk("irq_quiet", 32'(irq), 32'(m_irq()));
      pad_model(m_pad | 32'h1);
      pin_drv = m_pad;
      for (int k = 1; k <= CDC_LEN + 2; k++) begin
         tcb_vld = (k >= CDC_LEN + 1); tcb_wen = 1'b0; tcb_adr = 5'(3 << 2);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("irq_edge%0d", k), 32'(irq), 32'(k >= CDC_LEN + 2));
         if (k == CDC_LEN + 1) chk("rise_before", tcb_rdt, 32'h0);
         if (k == CDC_LEN + 2) chk("rise_after", tcb_rdt, m_rise);
      end
      tcb_vld = 1'b0;
      m_rdt = m_rise;
      bus_wr(3, 32'h1, 4'hF, e);
      m_write(3, 32'h1, 4'hF);
      chk("irq_lag", 32'(irq), 1);
      idle(1);
      chk("irq_drop", 32'(irq), 32'(m_irq()));

      // Clear of RISE[3] lands on the edge where rise_ev[3] fires; RISE[1] clears normally.
      set_pad(m_pad | 32'h0A);
      set_pad(m_pad & ~32'h08);
      pin_drv = m_pad | 32'h08;
      for (int k = 1; k <= CDC_LEN + 1; k++) begin
         tcb_vld = (k == CDC_LEN + 1); tcb_wen = 1'b1; tcb_adr = 5'(3 << 2);
         tcb_ben = 4'hF; tcb_wdt = 32'h0A;
         @(posedge clk);
         @(negedge clk);
      end
      tcb_vld = 1'b0; tcb_wen = 1'b0;
      m_write(3, 32'h0A, 4'hF);
      pad_model(m_pad | 32'h08);
      idle(2);
      rd_chk(3, "collide_rise");
      chk("collide_bit3", 32'(d[3]), 1);
      chk("collide_bit1", 32'(d[1]), 0);

      for (int it = 0; it < 60; it++) begin
         int          op, a;
         logic [31:0] rv;
         logic [3:0]  rb;
         op = $urandom_range(0, 2);
         a  = $urandom_range(0, 7);
         rv = $urandom;
         rb = 4'($urandom);
         case (op)
            0:       wr_chk(a, rv, rb, $sformatf("rnd_wr%0d", it));
            1:       rd_chk(a, $sformatf("rnd_rd%0d", it));
            default: set_pad(rv);
         endcase
         idle(1);
         chk($sformatf("rnd_irq%0d", it), 32'(irq), 32'(m_irq()));
      end

      // Reset while irq is high and a read is in flight.
      wr_chk(5, 32'hFFFF_FFFF, 4'hF, "pre_mskr");
      wr_chk(6, 32'hFFFF_FFFF, 4'hF, "pre_mskf");
      set_pad(~m_pad);
      chk("pre_irq", 32'(irq), 1);
      tcb_vld = 1'b1; tcb_wen = 1'b0; tcb_adr = 5'(3 << 2);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcb_vld = 1'b0;
      chk("mid_irq", 32'(irq), 0);
      chk("mid_rdt", tcb_rdt, 0);
      chk("mid_err", 32'(tcb_err), 0);
      idle(1);
      rst = 1'b0;
      m_reset();
      idle(CDC_LEN + 3);
      chk("post_irq", 32'(irq), 0);
      for (int a = 0; a < 8; a++) rd_chk(a, $sformatf("post%0d", a));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
